// File: rtl/delay_scheduler.sv
// ---------------------------------------------------------------------------
// delay_scheduler
//
// Upstream stage of the delay line. Every rising edge seen on the asynchronous
// pulse_in becomes a target timestamp (count + delay, wrapping) that is
// written into the downstream timestamp FIFO. One event can be parked while
// the FIFO is full. Events that cannot be kept, or whose target time has
// already arrived while still parked, are discarded and counted.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   pulse_in      asynchronous event input, rising edge = event
//   count         free-running timebase shared with the comparator
//   delay         requested delay in clk cycles, sampled per event
//   full          FIFO full flag
//   wr_en         FIFO write strobe (decoded from state and full)
//   data_out      target timestamp presented with wr_en
//   drop_count    saturating count of discarded events
//   overflow      sticky flag, set on any discard
//   clr_overflow  clears overflow and drop_count
// ---------------------------------------------------------------------------
module delay_scheduler #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_DELAY   = 2,
   parameter int DROP_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pulse_in,
   input  logic [WIDTH-1:0]      count,
   input  logic [WIDTH-1:0]      delay,
   input  logic                  full,
   output logic                  wr_en,
   output logic [WIDTH-1:0]      data_out,
   output logic [DROP_WIDTH-1:0] drop_count,
   output logic                  overflow,
   input  logic                  clr_overflow
);

   localparam logic [WIDTH-1:0] C_MIN_DELAY = WIDTH'(MIN_DELAY);

   typedef enum logic {
      IDLE,
      PEND
   } state_t;

   state_t                  r_state;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic                    r_prev;
   logic [WIDTH-1:0]        r_hold;
   logic [DROP_WIDTH-1:0]   r_dropCount;
   logic                    r_overflow;

   logic                    w_rise;
   logic [WIDTH-1:0]        w_effDelay;
   logic [WIDTH-1:0]        w_target;
   logic                    w_stale;
   logic                    w_drop;

   // Synchroniser chain plus the edge-detect flop. Everything resets to 1 so
   // that a pulse_in already high when reset lifts is not mistaken for a new
   // event; the input has to go low and then high again first.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // Edge detect, delay clamp and the wrapping target. The stale test only
   // matters while parked behind a full FIFO: once count has reached the
   // parked target, writing it would schedule an event a full wrap late.
   // A drop is either a newly arriving event that cannot be parked, or the
   // parked event going stale; if both coincide the stale one is discarded,
   // the new one is parked, and only a single drop is recorded.
   always_comb begin
      w_rise     = r_sync[SYNC_STAGES-1] & ~r_prev;
      w_effDelay = (delay < C_MIN_DELAY) ? C_MIN_DELAY : delay;
      w_target   = count + w_effDelay;
      w_stale    = (count == r_hold);
      w_drop     = (r_state == PEND) && full && (w_rise || w_stale);
   end

   // Scheduler state machine. In PEND the FIFO is written whenever it is not
   // full; a write always beats the stale test. A rise that lands in the
   // same cycle as a write is parked straight away so back-to-back events
   // give back-to-back writes. With the FIFO full the oldest event wins,
   // unless it has gone stale, in which case it is replaced or abandoned.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_hold  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  r_hold  <= w_target;
                  r_state <= PEND;
               end
            end
            PEND: begin
               if (!full) begin
                  if (w_rise) begin
                     r_hold <= w_target;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (w_stale) begin
                  if (w_rise) begin
                     r_hold <= w_target;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Discard bookkeeping. The counter saturates rather than wrapping so a
   // burst of losses is never reported as a small number. A drop in the
   // same cycle as a clear is still reported, leaving a count of one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dropCount <= '0;
         r_overflow  <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (clr_overflow) begin
            r_dropCount <= DROP_WIDTH'(1);
         end else if (r_dropCount != '1) begin
            r_dropCount <= r_dropCount + 1'b1;
         end
      end else if (clr_overflow) begin
         r_dropCount <= '0;
         r_overflow  <= 1'b0;
      end
   end

   // The write strobe is the one unregistered output so that the FIFO sees
   // a write in the very first cycle full drops.
   assign wr_en      = (r_state == PEND) && !full;
   assign data_out   = r_hold;
   assign drop_count = r_dropCount;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_delay_scheduler.sv
// ---------------------------------------------------------------------------
// tb_delay_scheduler
//
// Drives delay_scheduler cycle by cycle and compares every output against a
// behavioural model of the scheduler: a short history of sampled pulse
// levels, at most one parked target, and an integer discard tally. Directed
// scenarios come first, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_delay_scheduler;

   localparam int W    = 8;
   localparam int S    = 2;
   localparam int MIND = 2;
   localparam int DW   = 8;

   logic          clk;
   logic          rst;
   logic          pulse_in;
   logic [W-1:0]  count;
   logic [W-1:0]  delay;
   logic          full;
   logic          wr_en;
   logic [W-1:0]  data_out;
   logic [DW-1:0] drop_count;
   logic          overflow;
   logic          clr_overflow;

   int checks    = 0;
   int failures  = 0;
   int stepIdx   = 0;

   bit mSmp [0:S];
   bit mPend;
   int mHold;
   int mDrops;
   bit mOvf;

   int wrData [$];
   int wrStep [$];

   delay_scheduler #(
      .WIDTH      (W),
      .SYNC_STAGES(S),
      .MIN_DELAY  (MIND),
      .DROP_WIDTH (DW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pulse_in    (pulse_in),
      .count       (count),
      .delay       (delay),
      .full        (full),
      .wr_en       (wr_en),
      .data_out    (data_out),
      .drop_count  (drop_count),
      .overflow    (overflow),
      .clr_overflow(clr_overflow)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison point: counts it and reports any disagreement.
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i <= S; i++) mSmp[i] = 1'b1;
      mPend  = 1'b0;
      mHold  = 0;
      mDrops = 0;
      mOvf   = 1'b0;
   endtask

   // Reference behaviour at a clock edge, from the current input values.
   // mSmp[0] is the newest sample of pulse_in; an event is seen once the
   // rising edge has travelled S samples deep into the history.
   task automatic modelEdge();
      bit rise;
      bit drop;
      int eff;
      int tgt;
      if (rst) begin
         modelReset();
      end else begin
         rise = mSmp[S-1] && !mSmp[S];
         eff  = (int'(delay) < MIND) ? MIND : int'(delay);
         tgt  = (int'(count) + eff) % (1 << W);
         drop = 1'b0;
         if (!mPend) begin
            if (rise) begin
               mPend = 1'b1;
               mHold = tgt;
            end
         end else if (!full) begin
            if (rise) mHold = tgt;
            else      mPend = 1'b0;
         end else if (int'(count) == mHold) begin
            drop = 1'b1;
            if (rise) mHold = tgt;
            else      mPend = 1'b0;
         end else if (rise) begin
            drop = 1'b1;
         end
         if (drop) begin
            mOvf = 1'b1;
            if (clr_overflow)            mDrops = 1;
            else if (mDrops < (1 << DW) - 1) mDrops = mDrops + 1;
         end else if (clr_overflow) begin
            mDrops = 0;
            mOvf   = 1'b0;
         end
         for (int i = S; i > 0; i--) mSmp[i] = mSmp[i-1];
         mSmp[0] = pulse_in;
      end
   endtask

   // Compare every output against the model mid-cycle and log FIFO writes.
   task automatic checkOutput();
      checkVal("wr_en",      32'(wr_en),      32'(mPend && !full));
      checkVal("data_out",   32'(data_out),   mHold);
      checkVal("drop_count", 32'(drop_count), mDrops);
      checkVal("overflow",   32'(overflow),   32'(mOvf));
      if (wr_en === 1'b1) begin
         wrData.push_back(int'(data_out));
         wrStep.push_back(stepIdx);
      end
   endtask

   // Drive one cycle of inputs just after a rising edge, check at the
   // falling edge, then advance the model at the next rising edge.
   task automatic applyStimulus(input logic r, input logic p, input logic [W-1:0] c,
                                input logic [W-1:0] d, input logic f, input logic clr);
      rst          = r;
      pulse_in     = p;
      count        = c;
      delay        = d;
      full         = f;
      clr_overflow = clr;
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      modelEdge();
      #1;
      stepIdx++;
   endtask

   task automatic runSteps(input int n, input logic p, input logic [W-1:0] c,
                           input logic [W-1:0] d, input logic f);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, p, c, d, f, 1'b0);
   endtask

   initial begin
      int base;
      int k;
      int cnt;
      logic p;
      logic f;

      // Reset with pulse_in already high.
      rst = 1'b1; pulse_in = 1'b1; count = '0; delay = 8'd5;
      full = 1'b0; clr_overflow = 1'b0;
      @(posedge clk);
      @(posedge clk);
      modelReset();
      #1;
      runSteps(4, 1'b1, 8'h00, 8'd5, 1'b0);
      checkVal("reset_high_no_write", wrData.size(), 0);
      checkVal("reset_drop_count", 32'(drop_count), 0);

      // Single event: count 0x20, delay 10.
      runSteps(2, 1'b0, 8'h20, 8'd10, 1'b0);
      base = wrData.size();
      k    = stepIdx;
      runSteps(3, 1'b1, 8'h20, 8'd10, 1'b0);
      runSteps(3, 1'b0, 8'h20, 8'd10, 1'b0);
      checkVal("single_writes", wrData.size() - base, 1);
      if (wrData.size() > base) begin
         checkVal("single_data", wrData[base], 32'h2A);
         checkVal("single_latency", wrStep[base], k + 3);
      end

      // Wrap-around, then delay clamp.
      base = wrData.size();
      runSteps(3, 1'b1, 8'hFC, 8'h08, 1'b0);
      runSteps(3, 1'b0, 8'hFC, 8'h08, 1'b0);
      runSteps(3, 1'b1, 8'h10, 8'h00, 1'b0);
      runSteps(3, 1'b0, 8'h10, 8'h00, 1'b0);
      checkVal("wrap_clamp_writes", wrData.size() - base, 2);
      if (wrData.size() > base + 1) begin
         checkVal("wrap_data", wrData[base], 32'h04);
         checkVal("clamp_data", wrData[base+1], 32'h12);
      end

      // Back-pressure: parked for three full cycles, then written.
      runSteps(2, 1'b0, 8'h40, 8'd5, 1'b1);
      base = wrData.size();
      k    = stepIdx;
      runSteps(3, 1'b1, 8'h40, 8'd5, 1'b1);
      runSteps(3, 1'b0, 8'h40, 8'd5, 1'b1);
      runSteps(2, 1'b0, 8'h40, 8'd5, 1'b0);
      checkVal("bp_writes", wrData.size() - base, 1);
      if (wrData.size() > base) begin
         checkVal("bp_data", wrData[base], 32'h45);
         checkVal("bp_step", wrStep[base], k + 6);
      end
      checkVal("bp_drop_count", 32'(drop_count), 0);

      // Drop while parked, then the parked event goes stale, then clear.
      runSteps(2, 1'b0, 8'h20, 8'h10, 1'b1);
      base = wrData.size();
      runSteps(3, 1'b1, 8'h20, 8'h10, 1'b1);
      runSteps(2, 1'b0, 8'h20, 8'h10, 1'b1);
      runSteps(3, 1'b1, 8'h20, 8'h10, 1'b1);
      runSteps(2, 1'b0, 8'h20, 8'h10, 1'b1);
      checkVal("drop_count_one", 32'(drop_count), 1);
      checkVal("drop_overflow", 32'(overflow), 1);
      checkVal("drop_hold_kept", 32'(data_out), 32'h30);
      runSteps(1, 1'b0, 8'h30, 8'h10, 1'b1);
      checkVal("stale_drop_count", 32'(drop_count), 2);
      runSteps(2, 1'b0, 8'h31, 8'h10, 1'b0);
      checkVal("stale_no_write", wrData.size() - base, 0);
      applyStimulus(1'b0, 1'b0, 8'h31, 8'h10, 1'b0, 1'b1);
      checkVal("clr_drop_count", 32'(drop_count), 0);
      checkVal("clr_overflow", 32'(overflow), 0);

      // Rise coincides with a write of the parked event.
      runSteps(2, 1'b0, 8'h50, 8'd6, 1'b0);
      base = wrData.size();
      for (int i = 0; i < 7; i++) begin
         p = (i == 0 || i == 2);
         f = (i == 3);
         applyStimulus(1'b0, p, 8'(8'h50 + i), 8'd6, f, 1'b0);
      end
      checkVal("simul_writes", wrData.size() - base, 2);
      if (wrData.size() > base + 1) begin
         checkVal("simul_first", wrData[base], 32'h58);
         checkVal("simul_second", wrData[base+1], 32'h5A);
         checkVal("simul_consecutive", wrStep[base+1] - wrStep[base], 1);
      end
      checkVal("simul_no_drop", 32'(drop_count), 0);

      // Saturation: one parked event, then 300 dropped events.
      runSteps(2, 1'b0, 8'h00, 8'd20, 1'b1);
      for (int i = 0; i < 301; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h00, 8'd20, 1'b1, 1'b0);
         applyStimulus(1'b0, 1'b0, 8'h00, 8'd20, 1'b1, 1'b0);
      end
      checkVal("sat_drop_count", 32'(drop_count), 32'hFF);
      checkVal("sat_overflow", 32'(overflow), 1);
      applyStimulus(1'b0, 1'b1, 8'h00, 8'd20, 1'b1, 1'b1);
      checkVal("clr_with_drop_count", 32'(drop_count), 1);
      checkVal("clr_with_drop_ovf", 32'(overflow), 1);
      applyStimulus(1'b0, 1'b0, 8'h00, 8'd20, 1'b1, 1'b0);

      // Reset while an event is parked.
      applyStimulus(1'b1, 1'b0, 8'h00, 8'd20, 1'b1, 1'b0);
      full = 1'b0;
      #1;
      checkVal("rst_pend_wr_en", 32'(wr_en), 0);
      checkVal("rst_pend_data", 32'(data_out), 0);
      checkVal("rst_pend_drops", 32'(drop_count), 0);
      checkVal("rst_pend_ovf", 32'(overflow), 0);
      runSteps(3, 1'b0, 8'h00, 8'd20, 1'b0);

      // Randomized run with a free-running count.
      cnt = 0;
      p   = 1'b0;
      f   = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) p = ~p;
         if ($urandom_range(0, 7) == 0) f = ~f;
         applyStimulus(($urandom_range(0, 499) == 0), p, 8'(cnt),
                       8'($urandom_range(0, 15)), f, ($urandom_range(0, 49) == 0));
         cnt++;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/delay_scheduler.md
Name: delay_scheduler

Overview:
- Upstream stage of the delay line: converts each rising edge on an asynchronous input pulse into a target timestamp, target = count + delay, and writes it into the timestamp FIFO.
- The downstream comparator fires when the free-running count reaches the stored target.
- Synchronises the input and holds one pending event while the FIFO is full.
- Discards events that are lost or go stale, and counts each discard.

Parameters:
- WIDTH, 8: width of count, delay and timestamps; must match the FIFO and comparator width.
- SYNC_STAGES, 2: number of synchroniser flops on pulse_in; minimum 2.
- MIN_DELAY, 2: smallest effective delay; a smaller delay input is raised to this value.
- DROP_WIDTH, 8: width of the drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pulse_in  in  1  asynchronous event input; a rising edge is an event
- count  in  WIDTH  free-running timebase shared with the comparator
- delay  in  WIDTH  requested delay in clk cycles; sampled per event
- full  in  1  FIFO full flag
- wr_en  out  1  FIFO write strobe; the FIFO writes on a clk edge where wr_en=1
- data_out  out  WIDTH  target timestamp presented with wr_en
- drop_count  out  DROP_WIDTH  saturating count of discarded events
- overflow  out  1  sticky flag, set on any discard
- clr_overflow  in  1  clears overflow and drop_count

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Synchroniser flops and the edge-detect "prev" flop load 1. A pulse_in held high through reset therefore produces no event; an event needs a low-then-high after reset.
  - state=IDLE, hold=0, wr_en=0, data_out=0, drop_count=0, overflow=0.
  - Any pending event is lost and is not counted as a drop.
- Synchroniser: chain s[0..SYNC_STAGES-1], then prev <= s[last]. rise = s[last] & ~prev (combinational).
- Target computation, in the rise cycle:
  - eff = (delay < MIN_DELAY) ? MIN_DELAY : delay.
  - target = (count + eff) mod 2^WIDTH. The carry is discarded; wrap-around is legal.
  - count and delay are sampled in the rise cycle only.
- State machine:
  - IDLE: wr_en=0. On rise: hold <= target, go to PEND.
  - PEND: wr_en = ~full (combinational); data_out = hold at all times.
    - wr_en=1 and no rise: go to IDLE.
    - wr_en=1 and rise in the same cycle: the write completes; hold <= new target; stay in PEND.
    - full=1 and rise: the new event is dropped and the old hold is kept (oldest wins); drop.
    - full=1 and count == hold: the event is stale; discard it, go to IDLE; drop. If rise coincides, the new target loads into hold, state stays PEND, and only one drop is counted.
    - Stale check priority: a write when full=0 wins over the stale check.
- Drop accounting:
  - Each drop sets overflow and increments drop_count, saturating at all-ones.
  - clr_overflow zeroes both; a drop in the same cycle still sets overflow=1 and drop_count=1 (drop wins).
- Latency: pulse_in high before clk edge k -> rise during cycle k+SYNC_STAGES-1 -> wr_en=1 during cycle k+SYNC_STAGES, provided full=0. With the default of 2 stages, that is 2 cycles after the first sampling edge.
- Throughput: one event per cycle is sustainable when full=0. pulse_in must stay low for at least 1 cycle between events, or the edges merge.
- data_out stays stable for the whole time the design is in PEND.
- All outputs are registered except wr_en, which is decoded from state and full.

Test Plan:
- Single event: WIDTH=8, delay=10, count=0x20 in the rise cycle, full=0 -> exactly one wr_en pulse, data_out=0x2A, SYNC_STAGES cycles after the sampling edge.
- Wrap and clamp: count=0xFC, delay=0x08 -> data_out=0x04. Then delay=0, count=0x10 -> data_out=0x12 (MIN_DELAY applied).
- Back-pressure: full=1 when the event arrives, released after 3 cycles with count != hold -> wr_en asserts in the first full=0 cycle, data_out unchanged, drop_count=0.
- Drop and stale: full=1 held; event A (target 0x30) is held, event B arrives -> drop_count=1, overflow=1, hold stays 0x30. Count reaches 0x30 while full -> IDLE, drop_count=2. Pulse clr_overflow -> both 0.
- Simultaneous events: rise in the same cycle as a PEND write -> two consecutive wr_en cycles with distinct targets, no drops. Saturation: drop 300 events with DROP_WIDTH=8 -> drop_count=0xFF.
- Reset: pulse_in held high through rst, then rst released -> no wr_en. Assert rst mid-PEND -> wr_en=0 next cycle, all outputs 0, no drop counted.
